// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer BRAM arbiter.
// Imported by the arbiter top and its write FIFO.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR
  } gnt_t;

  localparam int FRAME_PIXELS_DEF = 307200;

endpackage

// File: rtl/fb_wr_fifo.sv
// Pixel write FIFO. dout is registered and updates only on a pop.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module fb_wr_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [PW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fb_bram_arbiter.sv
// Shares one BRAM port between the VGA reader (always wins) and the pixel
// write FIFO; a frame FSM paces capture and generates wrapping write addresses.
module fb_bram_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int FIFO_DEPTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int CONTINUOUS   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              pix_en_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_din_o,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              ovf_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

  state_t              state;
  gnt_t                gnt;
  logic [ADDR_W-1:0]   push_cnt;
  logic [ADDR_W-1:0]   wr_addr;
  logic [RD_LATENCY+1:0] rd_pipe;
  logic                accept;
  logic                pop;
  logic                drain_done;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  always_comb begin
    gnt = GNT_NONE;
    if (rd_req_i)         gnt = GNT_RD;
    else if (!fifo_empty) gnt = GNT_WR;
  end

  assign accept = (state == FILL) && pix_en_i;
  assign pop    = (gnt == GNT_WR);
  // No pushes happen in DRAIN, so the frame ends when the FIFO runs dry;
  // the empty term also releases a frame that lost pixels to overflow.
  assign drain_done = (state == DRAIN) &&
                      (fifo_empty || (pop && fifo_count == CW'(1)));

  assign busy_o     = (state != IDLE);
  assign rd_valid_o = rd_pipe[RD_LATENCY+1];

  fb_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (pix_i),
    .pop   (pop),
    .dout  (bram_din_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      push_cnt     <= '0;
      wr_addr      <= '0;
      ovf_o        <= 1'b0;
      frame_done_o <= 1'b0;
      bram_en_o    <= 1'b0;
      bram_we_o    <= 1'b0;
      bram_addr_o  <= '0;
      rd_pipe      <= '0;
      rd_data_o    <= '0;
    end else begin
      bram_en_o <= (gnt != GNT_NONE);
      bram_we_o <= pop;
      if (gnt == GNT_RD)  bram_addr_o <= rd_addr_i;
      else if (pop)       bram_addr_o <= wr_addr;

      frame_done_o <= pop && (wr_addr == LAST);
      if (pop) wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
      if (accept && fifo_full && !pop) ovf_o <= 1'b1;

      rd_pipe <= {rd_pipe[RD_LATENCY:0], gnt == GNT_RD};
      if (rd_pipe[RD_LATENCY]) rd_data_o <= bram_dout_i;

      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= FILL;
            wr_addr  <= '0;
            push_cnt <= '0;
            ovf_o    <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            if (push_cnt == LAST) begin
              push_cnt <= '0;
              state    <= DRAIN;
            end else begin
              push_cnt <= push_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state    <= (CONTINUOUS != 0) ? FILL : IDLE;
            wr_addr  <= '0;
            push_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Directed bench: dut_a (16-pixel frame), dut_b (continuous 4-pixel frame),
// dut_c (two-cycle BRAM read latency).
module tb_fb_bram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a signals
  logic        a_start = 0, a_pix_en = 0, a_rd_req = 0;
  logic [7:0]  a_pix = 0;
  logic [18:0] a_rd_addr = 0;
  logic [7:0]  a_rd_data, a_din, a_dout;
  logic        a_rd_valid, a_en, a_we, a_busy, a_done, a_ovf;
  logic [18:0] a_addr;

  // dut_b signals
  logic        b_start = 0, b_pix_en = 0;
  logic [7:0]  b_pix = 0;
  logic [7:0]  b_rd_data, b_din;
  logic        b_rd_valid, b_en, b_we, b_busy, b_done, b_ovf;
  logic [18:0] b_addr;

  // dut_c signals
  logic        c_rd_req = 0;
  logic [18:0] c_rd_addr = 0;
  logic [7:0]  c_rd_data, c_din, c_dout, c_d1, c_d2;
  logic        c_rd_valid, c_en, c_we, c_busy, c_done, c_ovf;
  logic [18:0] c_addr;

  fb_bram_arbiter #(.FRAME_PIXELS(16), .FIFO_DEPTH(8), .RD_LATENCY(1), .CONTINUOUS(0)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .pix_i(a_pix), .pix_en_i(a_pix_en),
    .rd_req_i(a_rd_req), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid),
    .bram_en_o(a_en), .bram_we_o(a_we), .bram_addr_o(a_addr), .bram_din_o(a_din),
    .bram_dout_i(a_dout), .busy_o(a_busy), .frame_done_o(a_done), .ovf_o(a_ovf));

  fb_bram_arbiter #(.FRAME_PIXELS(4), .FIFO_DEPTH(8), .RD_LATENCY(1), .CONTINUOUS(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .pix_i(b_pix), .pix_en_i(b_pix_en),
    .rd_req_i(1'b0), .rd_addr_i(19'd0), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid),
    .bram_en_o(b_en), .bram_we_o(b_we), .bram_addr_o(b_addr), .bram_din_o(b_din),
    .bram_dout_i(8'd0), .busy_o(b_busy), .frame_done_o(b_done), .ovf_o(b_ovf));

  fb_bram_arbiter #(.FRAME_PIXELS(16), .FIFO_DEPTH(8), .RD_LATENCY(2), .CONTINUOUS(0)) dut_c (
    .clk(clk), .rst(rst), .start_i(1'b0), .pix_i(8'd0), .pix_en_i(1'b0),
    .rd_req_i(c_rd_req), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data), .rd_valid_o(c_rd_valid),
    .bram_en_o(c_en), .bram_we_o(c_we), .bram_addr_o(c_addr), .bram_din_o(c_din),
    .bram_dout_i(c_dout), .busy_o(c_busy), .frame_done_o(c_done), .ovf_o(c_ovf));

  // BRAM models: read contents are a fixed function of the address.
  always @(posedge clk) begin
    if (a_en && !a_we) a_dout <= a_addr[7:0] ^ 8'h5A;
    if (c_en && !c_we) c_d1 <= (c_addr == 19'd5) ? 8'hA5 : c_addr[7:0];
    c_d2 <= c_d1;
  end
  assign c_dout = c_d2;

  logic [18:0] b_wq_addr[$];
  logic [7:0]  b_wq_data[$];
  int          b_done_cnt = 0;
  always @(posedge clk) begin
    if (!rst && b_en && b_we) begin
      b_wq_addr.push_back(b_addr);
      b_wq_data.push_back(b_din);
    end
    if (!rst && b_done) b_done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic st, input logic pe, input logic [7:0] px,
                        input logic rq, input logic [18:0] ra);
    a_start = st; a_pix_en = pe; a_pix = px; a_rd_req = rq; a_rd_addr = ra;
    tick();
  endtask

  task automatic chk_wr_a(input string name, input int addr, input int data);
    chk({name, " en"}, 32'(a_en), 32'd1);
    chk({name, " we"}, 32'(a_we), 32'd1);
    chk({name, " addr"}, 32'(a_addr), 32'(addr));
    chk({name, " din"}, 32'(a_din), 32'(data));
  endtask

  typedef struct {
    logic        start, pix_en;
    logic [7:0]  pix;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        en, we;
    logic [18:0] addr;
    logic [7:0]  din;
    logic        done, busy, ovf;
  } vec_t;

  vec_t tv[19];

  initial begin
    // Fill-without-reads table: vector i's outputs are sampled just after its edge.
    for (int i = 0; i < 19; i++) begin
      tv[i] = '{default: '0};
      tv[i].busy = (i < 17);
      if (i == 0) tv[i].start = 1'b1;
      if (i >= 1 && i <= 16) begin
        tv[i].pix_en = 1'b1;
        tv[i].pix    = 8'(i - 1);
      end
      if (i >= 2 && i <= 17) begin
        tv[i].en   = 1'b1;
        tv[i].we   = 1'b1;
        tv[i].addr = 19'(i - 2);
        tv[i].din  = 8'(i - 2);
      end
      tv[i].done = (i == 17);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst en", 32'(a_en), 0);
    chk("rst valid", 32'(a_rd_valid), 0);
    chk("rst busy", 32'(a_busy), 0);
    chk("rst done", 32'(a_done), 0);
    chk("rst ovf", 32'(a_ovf), 0);
    chk("rst addr", 32'(a_addr), 0);
    chk("rst din", 32'(a_din), 0);
    chk("rst rd_data", 32'(a_rd_data), 0);
    rst = 1'b0;
    tick();

    // Table-driven frame fill
    for (int i = 0; i < 19; i++) begin
      step_a(tv[i].start, tv[i].pix_en, tv[i].pix, tv[i].rd_req, tv[i].rd_addr);
      chk($sformatf("fill[%0d] en", i), 32'(a_en), 32'(tv[i].en));
      chk($sformatf("fill[%0d] done", i), 32'(a_done), 32'(tv[i].done));
      chk($sformatf("fill[%0d] busy", i), 32'(a_busy), 32'(tv[i].busy));
      chk($sformatf("fill[%0d] ovf", i), 32'(a_ovf), 32'(tv[i].ovf));
      if (tv[i].en) begin
        chk($sformatf("fill[%0d] we", i), 32'(a_we), 32'(tv[i].we));
        chk($sformatf("fill[%0d] addr", i), 32'(a_addr), 32'(tv[i].addr));
        chk($sformatf("fill[%0d] din", i), 32'(a_din), 32'(tv[i].din));
      end
    end

    // Read priority: 20 reads while 16 pixels stream into an 8-deep FIFO
    step_a(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step_a(0, i < 16, 8'(8'h40 + i), 1, 19'(100 + i));
      chk($sformatf("rp[%0d] en", i), 32'(a_en), 1);
      chk($sformatf("rp[%0d] we", i), 32'(a_we), 0);
      chk($sformatf("rp[%0d] addr", i), 32'(a_addr), 32'(100 + i));
      chk($sformatf("rp[%0d] valid", i), 32'(a_rd_valid), 32'(i >= 2));
      if (i >= 2) chk($sformatf("rp[%0d] data", i), 32'(a_rd_data), 32'((98 + i) ^ 8'h5A));
      if (i == 7) chk("rp ovf before 9th", 32'(a_ovf), 0);
      if (i == 8) chk("rp ovf after 9th", 32'(a_ovf), 1);
    end
    for (int j = 0; j < 8; j++) begin
      step_a(0, 0, 0, 0, 0);
      chk_wr_a($sformatf("rp drain[%0d]", j), j, 8'h40 + j);
      chk($sformatf("rp drain[%0d] valid", j), 32'(a_rd_valid), 32'(j < 2));
      if (j < 2) chk($sformatf("rp tail[%0d] data", j), 32'(a_rd_data), 32'((118 + j) ^ 8'h5A));
    end
    chk("rp busy after drain", 32'(a_busy), 0);

    // Full FIFO with simultaneous push and pop
    step_a(1, 0, 0, 0, 0);
    chk("full ovf cleared", 32'(a_ovf), 0);
    for (int k = 0; k < 8; k++) step_a(0, 1, 8'(8'h80 + k), 1, 19'd200);
    step_a(0, 1, 8'h88, 0, 0);
    chk_wr_a("full pop", 0, 8'h80);
    chk("full no ovf", 32'(a_ovf), 0);
    step_a(0, 0, 0, 1, 19'd200);
    chk("full hold ovf", 32'(a_ovf), 0);
    step_a(0, 1, 8'h89, 1, 19'd200);
    chk("full drop ovf", 32'(a_ovf), 1);
    for (int k = 1; k <= 8; k++) begin
      step_a(0, 0, 0, 0, 0);
      chk_wr_a($sformatf("full drain[%0d]", k), k, 8'h80 + k);
    end
    chk("full still filling", 32'(a_busy), 1);

    // Reset mid-FILL with three pixels queued behind reads
    for (int k = 0; k < 3; k++) step_a(0, 1, 8'(8'h91 + k), 1, 19'd300);
    rst = 1'b1;
    #1;
    chk("mid rst en", 32'(a_en), 0);
    chk("mid rst busy", 32'(a_busy), 0);
    chk("mid rst ovf", 32'(a_ovf), 0);
    chk("mid rst valid", 32'(a_rd_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_a(0, 0, 0, 0, 0);
      chk($sformatf("post rst[%0d] en", k), 32'(a_en), 0);
      chk($sformatf("post rst[%0d] valid", k), 32'(a_rd_valid), 0);
    end
    step_a(1, 0, 0, 0, 0);
    step_a(0, 1, 8'h33, 0, 0);
    step_a(0, 0, 0, 0, 0);
    chk_wr_a("post rst first write", 0, 8'h33);

    // Continuous mode: two back-to-back 4-pixel frames, one start
    b_start = 1; tick(); b_start = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        b_pix_en = 1; b_pix = 8'(8'h10 + 4 * f + k); tick();
      end
      b_pix_en = 0; tick();
    end
    repeat (3) tick();
    chk("cont done pulses", 32'(b_done_cnt), 2);
    chk("cont write count", 32'(b_wq_addr.size()), 8);
    for (int k = 0; k < 8 && k < b_wq_addr.size(); k++) begin
      chk($sformatf("cont addr[%0d]", k), 32'(b_wq_addr[k]), 32'(k % 4));
      chk($sformatf("cont data[%0d]", k), 32'(b_wq_data[k]), 32'(8'h10 + k));
    end
    chk("cont busy", 32'(b_busy), 1);
    chk("cont ovf", 32'(b_ovf), 0);

    // Two-cycle read latency: valid four cycles after the request
    c_rd_req = 1; c_rd_addr = 19'd5; tick();
    c_rd_req = 0; c_rd_addr = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk($sformatf("lat2 valid[%0d]", k), 32'(c_rd_valid), 32'(k == 3));
      if (k == 3) chk("lat2 data", 32'(c_rd_data), 32'hA5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_bram_arbiter.md
Name: fb_bram_arbiter

Overview:
- Shares one BRAM port between two requesters: the pixel write stream from the SoC core and the VGA read requester.
- VGA reads are real-time and always win arbitration.
- Incoming pixels go into a small write FIFO, which drains into the BRAM in cycles with no read.
- A frame-sequencing FSM controls when a frame is captured. It generates write addresses, wraps them at the frame boundary and reports frame completion and overflow.

Parameters:
- ADDR_W, 19, BRAM address width.
- DATA_W, 8, pixel width.
- FRAME_PIXELS, 307200, pixels per frame (640x480); last write address is FRAME_PIXELS-1.
- FIFO_DEPTH, 8, write FIFO entries; power of two, at least 2.
- RD_LATENCY, 1, BRAM read latency in cycles; 1 or 2.
- CONTINUOUS, 0, 1 = restart capture automatically after each frame.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle pulse; begins capture of one frame.
- pix_i  in  DATA_W  pixel data.
- pix_en_i  in  1  pixel valid; no backpressure.
- rd_req_i  in  1  VGA read request.
- rd_addr_i  in  ADDR_W  VGA read address.
- rd_data_o  out  DATA_W  read data.
- rd_valid_o  out  1  rd_data_o valid.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  1  1 = write, 0 = read.
- bram_addr_o  out  ADDR_W  BRAM address.
- bram_din_o  out  DATA_W  BRAM write data.
- bram_dout_i  in  DATA_W  BRAM read data.
- busy_o  out  1  state is FILL or DRAIN.
- frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is written.
- ovf_o  out  1  sticky: a pixel was dropped; cleared by start_i.

Behaviour:
- Reset values: all outputs 0; FIFO empty; write address 0; state IDLE.
- Reset asserted mid-operation aborts everything. In-flight reads produce no rd_valid_o.
- FSM states:
  - IDLE: pixels ignored, not counted as overflow. start_i -> FILL; write address := 0; ovf_o := 0.
  - FILL: pixels with pix_en_i=1 are pushed into the FIFO. When the push count reaches FRAME_PIXELS -> DRAIN; further pixels are ignored.
  - DRAIN: FIFO continues to empty. When the last entry is written to address FRAME_PIXELS-1: frame_done_o pulses that cycle, then -> IDLE (CONTINUOUS=0) or -> FILL with address 0 (CONTINUOUS=1).
  - start_i outside IDLE is ignored.
- Arbitration, one BRAM access per cycle, combinational grant with registered BRAM outputs:
  - rd_req_i=1: read grant. Next cycle bram_en_o=1, bram_we_o=0, bram_addr_o=rd_addr_i.
  - Else, FIFO non-empty: pop. Next cycle bram_en_o=1, bram_we_o=1, bram_addr_o=write address, bram_din_o=popped pixel; write address increments.
  - Else: bram_en_o=0.
- Read timing:
  - rd_valid_o rises exactly RD_LATENCY+2 cycles after the rd_req_i cycle.
  - rd_data_o is registered from bram_dout_i.
  - Back-to-back requests give back-to-back valids.
- Write address wraps from FRAME_PIXELS-1 to 0. It never exceeds FRAME_PIXELS-1.
- FIFO rules:
  - A push when full with no pop in the same cycle: pixel dropped, ovf_o := 1; the frame push count still increments.
  - A push and a pop when full in the same cycle: both occur.
  - A push and a pop when empty in the same cycle: no bypass; the pop waits for the next cycle.
- Count widths: push counter and write address are ADDR_W wide; FIFO count is $clog2(FIFO_DEPTH)+1 wide.

Decomposition:
- Package fb_arb_pkg:
  - fsm state enum {IDLE, FILL, DRAIN};
  - FRAME_PIXELS default constant;
  - grant encoding enum {GNT_NONE, GNT_RD, GNT_WR}.
- Sub-module fb_wr_fifo: synchronous FIFO of width DATA_W and depth FIFO_DEPTH, with full/empty flags and registered read.
- Arbiter, FSM and read-valid shift register live in the top module.

Test Plan:
- Reset sequence: assert rst mid-FILL with 3 pixels queued -> all outputs 0, FIFO empty. After release, bram_en_o stays 0 until start_i.
- Fill without reads (FRAME_PIXELS=16): start_i, then 16 consecutive pixels 0x00..0x0F -> writes to addresses 0..15 with matching data. frame_done_o pulses once on the address-15 write; state returns to IDLE; ovf_o=0.
- Read priority: rd_req_i held for 20 cycles (addresses 100..119) while pixels stream (FIFO_DEPTH=8):
  - all 20 reads are issued;
  - rd_valid_o appears 3 cycles after each request (RD_LATENCY=1);
  - ovf_o=1 after the 9th unqueued pixel;
  - after reads stop, queued pixels are written to consecutive addresses.
- Full FIFO with simultaneous pop: FIFO full, one free cycle with pix_en_i=1 -> push accepted, no overflow, count stays 8.
- CONTINUOUS=1, FRAME_PIXELS=4, 8 pixels -> two frame_done_o pulses. Second frame writes addresses 0..3 again; no start_i needed.
- Read with RD_LATENCY=2: a single request at address 5 while BRAM holds 0xA5 -> rd_valid_o high 4 cycles later for exactly one cycle, rd_data_o=0xA5.
